wb_regfile: RTL and testbench

- Writeback-side consumer of the MEM/WB pipeline outputs: the architectural integer register file of the pipeline.
- Commits the WB-stage result to the rd register. The result is either the load/ALU data or the link address for jumps.
- Serves two combinational read ports to the decode stage, with optional same-cycle write-to-read bypass.
- Also provides a debug read port, a retired-write counter and a sticky conflict flag.

---
 rtl/wb_regfile.sv | 64 ++++++
 tb/tb_wb_regfile.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: architectural integer register file fed by the MEM/WB stage.
// Two combinational read ports with optional write bypass, a registered debug port, a write counter and a conflict flag.
module wb_regfile #(
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  WB_data_mem,
    input  logic [4:0]       WB_rd,
    input  logic             WB_we,
    input  logic [XLEN-1:0]  WB_link_addr,
    input  logic             WB_link_we,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    output logic [XLEN-1:0]  ID_rs1_data,
    output logic [XLEN-1:0]  ID_rs2_data,
    input  logic [4:0]       dbg_addr,
    output logic [XLEN-1:0]  dbg_data,
    output logic [CNT_W-1:0] wr_count,
    output logic             conflict_err
);
    logic [XLEN-1:0]  regs_q [1:31];
    logic [XLEN-1:0]  dbg_q, dbg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             conf_q, conf_d;
    logic             wr_en;
    logic [XLEN-1:0]  wr_data;

    assign wr_en   = (WB_we | WB_link_we) & (WB_rd != 5'd0);
    assign wr_data = WB_link_we ? WB_link_addr : WB_data_mem;

    // x0 is not stored; index 0 is decoded to zero before touching the array
    function automatic logic [XLEN-1:0] arr_rd(input logic [4:0] idx);
        return (idx == 5'd0) ? '0 : regs_q[idx];
    endfunction

    always_comb begin
        ID_rs1_data = (BYPASS && wr_en && ID_rs1 == WB_rd) ? wr_data : arr_rd(ID_rs1);
        ID_rs2_data = (BYPASS && wr_en && ID_rs2 == WB_rd) ? wr_data : arr_rd(ID_rs2);
        dbg_d       = arr_rd(dbg_addr);
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, wr_en};
        conf_d      = conf_q | (WB_we & WB_link_we);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) regs_q[i] <= '0;
            dbg_q  <= '0;
            cnt_q  <= '0;
            conf_q <= 1'b0;
        end else begin
            if (wr_en) regs_q[WB_rd] <= wr_data;
            dbg_q  <= dbg_d;
            cnt_q  <= cnt_d;
            conf_q <= conf_d;
        end
    end

    assign dbg_data     = dbg_q;
    assign wr_count     = cnt_q;
    assign conflict_err = conf_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of wb_regfile with bypass on, bypass off and a 4-bit counter.
// All three instances share one stimulus stream.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_mem = '0, link_addr = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0, dbg_addr = '0;
    logic        we = 1'b0, link_we = 1'b0;
    logic [31:0] b1_rs1, b1_rs2, b1_dbg, b1_cnt;
    logic [31:0] b0_rs1, b0_rs2, b0_dbg, b0_cnt;
    logic [31:0] c4_rs1, c4_rs2, c4_dbg;
    logic [3:0]  c4_cnt;
    logic        b1_conf, b0_conf, c4_conf;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    wb_regfile u_b1 (.clk(clk), .rst(rst), .WB_data_mem(data_mem), .WB_rd(rd), .WB_we(we),
        .WB_link_addr(link_addr), .WB_link_we(link_we), .ID_rs1(rs1), .ID_rs2(rs2),
        .ID_rs1_data(b1_rs1), .ID_rs2_data(b1_rs2), .dbg_addr(dbg_addr), .dbg_data(b1_dbg),
        .wr_count(b1_cnt), .conflict_err(b1_conf));
    wb_regfile #(.BYPASS(1'b0)) u_b0 (.clk(clk), .rst(rst), .WB_data_mem(data_mem), .WB_rd(rd), .WB_we(we),
        .WB_link_addr(link_addr), .WB_link_we(link_we), .ID_rs1(rs1), .ID_rs2(rs2),
        .ID_rs1_data(b0_rs1), .ID_rs2_data(b0_rs2), .dbg_addr(dbg_addr), .dbg_data(b0_dbg),
        .wr_count(b0_cnt), .conflict_err(b0_conf));
    wb_regfile #(.CNT_W(4)) u_c4 (.clk(clk), .rst(rst), .WB_data_mem(data_mem), .WB_rd(rd), .WB_we(we),
        .WB_link_addr(link_addr), .WB_link_we(link_we), .ID_rs1(rs1), .ID_rs2(rs2),
        .ID_rs1_data(c4_rs1), .ID_rs2_data(c4_rs2), .dbg_addr(dbg_addr), .dbg_data(c4_dbg),
        .wr_count(c4_cnt), .conflict_err(c4_conf));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        link_we = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        // fill every register, then reset asynchronously mid-cycle
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; rd = 5'(i); data_mem = 32'h01010101 * i;
            tick();
        end
        idle();
        rs1 = 5'd31; rs2 = 5'd5;
        #1;
        chk("fill_rs1", b1_rs1, 64'h1F1F1F1F);
        chk("fill_rs2", b0_rs2, 64'h05050505);
        chk("fill_cnt", b1_cnt, 64'd31);
        chk("fill_cnt4", c4_cnt, 64'd15);
        rst = 1'b1;
        #1;
        chk("rst_rs1", b1_rs1, 64'h0);
        chk("rst_rs2", b1_rs2, 64'h0);
        chk("rst_cnt", b1_cnt, 64'h0);
        chk("rst_dbg", b1_dbg, 64'h0);
        chk("rst_conf", b1_conf, 64'h0);
        #1 rst = 1'b0;
        tick();
        // basic commit with dbg showing pre-write value first
        we = 1'b1; rd = 5'd5; data_mem = 32'hDEADBEEF; rs1 = 5'd5; dbg_addr = 5'd5;
        #1;
        chk("commit_byp1", b1_rs1, 64'hDEADBEEF);
        chk("commit_byp0", b0_rs1, 64'h0);
        tick();
        idle();
        #1;
        chk("commit_rs1", b1_rs1, 64'hDEADBEEF);
        chk("commit_rs1_b0", b0_rs1, 64'hDEADBEEF);
        chk("commit_cnt", b1_cnt, 64'd1);
        chk("dbg_prewrite", b1_dbg, 64'h0);
        tick();
        chk("dbg_post", b1_dbg, 64'hDEADBEEF);
        // link priority and sticky conflict
        we = 1'b1; link_we = 1'b1; rd = 5'd1; data_mem = 32'h11; link_addr = 32'h1004; rs1 = 5'd1;
        #1;
        chk("link_byp", b1_rs1, 64'h1004);
        chk("conf_before", b1_conf, 64'h0);
        tick();
        idle();
        #1;
        chk("link_rs1", b0_rs1, 64'h1004);
        chk("conf_set", b1_conf, 64'h1);
        chk("link_cnt", b1_cnt, 64'd2);
        for (int i = 0; i < 10; i++) tick();
        chk("conf_sticky", b1_conf, 64'h1);
        // x0 writes discarded
        we = 1'b1; rd = 5'd0; data_mem = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd0;
        #1;
        chk("x0_rs1_same", b1_rs1, 64'h0);
        chk("x0_rs2_same", b1_rs2, 64'h0);
        tick();
        idle();
        #1;
        chk("x0_rs1_next", b1_rs1, 64'h0);
        chk("x0_rs2_next", b0_rs2, 64'h0);
        chk("x0_cnt", b1_cnt, 64'd2);
        // bypass vs no bypass
        we = 1'b1; rd = 5'd7; data_mem = 32'hA;
        tick();
        data_mem = 32'hB; rs2 = 5'd7;
        #1;
        chk("byp1_same", b1_rs2, 64'hB);
        chk("byp0_same", b0_rs2, 64'hA);
        tick();
        idle();
        #1;
        chk("byp0_next", b0_rs2, 64'hB);
        chk("byp_cnt", b1_cnt, 64'd4);
        // reset held across an edge drops the pending write
        we = 1'b1; rd = 5'd9; data_mem = 32'h99; rst = 1'b1;
        tick();
        idle();
        rst = 1'b0;
        rs1 = 5'd9;
        #1;
        chk("rst_drop_rs1", b1_rs1, 64'h0);
        chk("rst_drop_cnt", b1_cnt, 64'h0);
        chk("rst_conf_clr", b1_conf, 64'h0);
        tick();
        // counter wrap on the 4-bit instance
        rs1 = 5'd3;
        for (int k = 1; k <= 17; k++) begin
            we = 1'b1; rd = 5'd3; data_mem = 32'h300 + k;
            tick();
        end
        idle();
        #1;
        chk("wrap_cnt4", c4_cnt, 64'd1);
        chk("wrap_cnt32", b1_cnt, 64'd17);
        chk("wrap_reg", c4_rs1, 64'h311);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
